// File: rtl/booth_mult_if.sv
// Start/operand/result bundle between the MIPS control unit and the Booth multiplier.
// The master is the control unit and the slave is the multiplier.
interface booth_mult_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output a,
    output b,
    input  hi,
    input  lo,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output hi,
    output lo,
    output busy,
    output done
  );
endinterface

// File: rtl/booth_mult.sv
// Signed 32x32 radix-2 Booth multiplier. It performs one step per clock and feeds the HI/LO registers.
// Optional macro BOOTH_MULT_ZERO_SKIP_EN: a zero operand completes directly with a zero product.
module booth_mult (
  input  logic         clk,
  input  logic         reset,
  booth_mult_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [32:0] m_q, m_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [32:0] acc_sum;
  logic        zero_op;

`ifdef BOOTH_MULT_ZERO_SKIP_EN
  assign zero_op = (bus.a == 32'd0) || (bus.b == 32'd0);
`else
  assign zero_op = 1'b0;
`endif

  // The 33-bit accumulator keeps A - M exact when M is -2^31.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + m_q;
      2'b10:   acc_sum = acc_q - m_q;
      default: acc_sum = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          m_d   = {bus.a[31], bus.a};
          q_d   = bus.b;
          acc_d = 33'd0;
          qm1_d = 1'b0;
          cnt_d = 5'd0;
          if (zero_op) begin
            hi_d    = 32'd0;
            lo_d    = 32'd0;
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        acc_d = {acc_sum[32], acc_sum[32:1]};
        q_d   = {acc_sum[0], q_q[31:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          hi_d    = acc_d[31:0];
          lo_d    = q_d;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      m_q     <= 33'd0;
      acc_q   <= 33'd0;
      q_q     <= 32'd0;
      qm1_q   <= 1'b0;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_booth_mult.sv
// Directed and randomised checks of booth_mult against hand-computed products and a 64-bit model.
module tb_booth_mult;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

`ifdef BOOTH_MULT_ZERO_SKIP_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  always #5 clk = ~clk;

  booth_mult_if bus ();

  booth_mult dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one start in the current cycle and then waits (with a bound) for done.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.hi !== 32'd0) $display("FAIL reset_hi got %h want 0", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'd0) $display("FAIL reset_lo got %h want 0", bus.lo); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_basic();
    int lat;
    bus.a     = 32'd7;
    bus.b     = 32'hFFFF_FFFD;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) $display("FAIL basic_busy_rise got %b want 1", bus.busy); else passed++;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    checks++; if (lat !== 32) $display("FAIL basic_latency got %0d want 32", lat); else passed++;
    checks++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFEB)
      $display("FAIL basic_7x-3 got %h_%h want ffffffff_ffffffeb", bus.hi, bus.lo);
    else passed++;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", bus.done, bus.busy);
    else passed++;
  endtask

  task automatic test_corners();
    int lat;
    run_op(32'h8000_0000, 32'h8000_0000, lat);
    checks++; if (lat !== 32) $display("FAIL min_latency got %0d want 32", lat); else passed++;
    checks++;
    if ({bus.hi, bus.lo} !== 64'h4000_0000_0000_0000)
      $display("FAIL min_x_min got %h_%h want 40000000_00000000", bus.hi, bus.lo);
    else passed++;
    tick();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0000_0000_0001)
      $display("FAIL m1_x_m1 got %h_%h want 00000000_00000001", bus.hi, bus.lo);
    else passed++;
    tick();
  endtask

  // The previous result is -1 * -1 = 1; it must hold through the whole RUN.
  task automatic test_start_ignored();
    int n_done;
    int done_at;
    logic [63:0] res;
    n_done  = 0;
    done_at = -1;
    res     = '0;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    checks++;
    if ({bus.hi, bus.lo} !== 64'd1)
      $display("FAIL hold_during_run got %h_%h want 00000000_00000001", bus.hi, bus.lo);
    else passed++;
    bus.a     = 32'd100;
    bus.b     = 32'd100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h0BAD_F00D;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        n_done++;
        done_at = i;
        res = {bus.hi, bus.lo};
      end
    end
    checks++; if (n_done !== 1) $display("FAIL ignored_done_count got %0d want 1", n_done); else passed++;
    checks++; if (done_at !== 21) $display("FAIL ignored_latency got %0d want 21", done_at); else passed++;
    checks++;
    if (res !== 64'd30) $display("FAIL ignored_5x6 got %h want 000000000000001e", res);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int n_done;
    int lat;
    n_done    = 0;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h9ABC_DEF0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL midreset_flags got busy=%b done=%b want 0 0", bus.busy, bus.done);
    else passed++;
    checks++;
    if ({bus.hi, bus.lo} !== 64'd0) $display("FAIL midreset_result got %h_%h want 0", bus.hi, bus.lo);
    else passed++;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) n_done++;
    end
    checks++; if (n_done !== 0) $display("FAIL midreset_no_done got %0d want 0", n_done); else passed++;
    run_op(32'h1234_5678, 32'h9ABC_DEF0, lat);
    checks++; if (lat !== 32) $display("FAIL fresh_latency got %0d want 32", lat); else passed++;
    checks++;
    if ({bus.hi, bus.lo} !== 64'hF8CC_93D6_242D_2080)
      $display("FAIL fresh_result got %h_%h want f8cc93d6_242d2080", bus.hi, bus.lo);
    else passed++;
    tick();
  endtask

  task automatic test_zero();
    int lat;
    int exp_lat;
    exp_lat = Skip ? 0 : 32;
    run_op(32'd0, 32'h0000_1234, lat);
    checks++; if (lat !== exp_lat) $display("FAIL zero_latency got %0d want %0d", lat, exp_lat); else passed++;
    checks++;
    if ({bus.hi, bus.lo} !== 64'd0) $display("FAIL zero_result got %h_%h want 0", bus.hi, bus.lo);
    else passed++;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL zero_busy_fall got %b want 0", bus.busy); else passed++;
  endtask

  // Each start is issued in the first IDLE cycle after the previous done.
  task automatic test_back_to_back();
    int lat;
    int exp_lat;
    logic [31:0] av;
    logic [31:0] bv;
    longint prod;
    for (int n = 0; n < 1000; n++) begin
      av = $urandom();
      bv = $urandom();
      prod = longint'($signed(av)) * longint'($signed(bv));
      exp_lat = (Skip && (av == 0 || bv == 0)) ? 0 : 32;
      run_op(av, bv, lat);
      checks++;
      if (lat !== exp_lat) $display("FAIL b2b_latency[%0d] got %0d want %0d", n, lat, exp_lat);
      else passed++;
      checks++;
      if ({bus.hi, bus.lo} !== prod)
        $display("FAIL b2b_result[%0d] %h*%h got %h_%h want %h", n, av, bv, bus.hi, bus.lo, prod);
      else passed++;
      tick();
    end
  endtask

  initial begin
    void'($urandom(32'd12345));
    test_reset();
    test_basic();
    test_corners();
    test_start_ignored();
    test_reset_mid_run();
    test_zero();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
